// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM arbiter: FSM states, requester IDs
// and the default timing/width constants.
package sram_pkg;

  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned ADDR_W_DEF      = 20;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    LDR = 1'b1
  } port_e;

  // Round-robin pick: on a tie the port not served last wins.
  function automatic port_e rr_pick(input logic cpu_req, input logic ldr_req,
                                    input port_e last);
    if (cpu_req && ldr_req) return (last == CPU) ? LDR : CPU;
    return cpu_req ? CPU : LDR;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-port (CPU / program loader) arbiter for an asynchronous 16-bit SRAM.
// Each transfer: one IDLE grant cycle, WAIT_CYCLES strobe cycles, one DONE cycle.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_rdy,
  output logic [DATA_W-1:0] ldr_rdata,

  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              UB_N,
  output logic              LB_N,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_sram,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_from_sram
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  port_e               gnt_q, gnt_d;
  port_e               last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;

  port_e               sel;
  logic                busy;
  logic                in_access;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= CPU;
      last_q      <= LDR;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    sel         = rr_pick(cpu_req, ldr_req, last_q);

    unique case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = (sel == CPU) ? cpu_we    : ldr_we;
          addr_d  = (sel == CPU) ? cpu_addr  : ldr_addr;
          wdata_d = (sel == CPU) ? cpu_wdata : ldr_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is captured on the final strobe edge, after the full access time.
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q == CPU) cpu_rdata_d = Data_from_sram;
            else              ldr_rdata_d = Data_from_sram;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign in_access = (state_q == ACCESS);

  always_comb begin
    CE_N         = !busy;
    UB_N         = !busy;
    LB_N         = !busy;
    OE_N         = !(in_access && !we_q);
    WE_N         = !(in_access && we_q);
    // Write data stays driven through DONE to cover the SRAM data-hold time.
    Data_oe      = busy && we_q;
    ADDR         = busy ? addr_q : '0;
    Data_to_sram = wdata_q;
    cpu_rdy      = (state_q == DONE) && (gnt_q == CPU);
    ldr_rdy      = (state_q == DONE) && (gnt_q == LDR);
    cpu_rdata    = cpu_rdata_q;
    ldr_rdata    = ldr_rdata_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (WAIT_CYCLES 1, 2, 15) share stimulus and
// are compared every cycle against a transfer-timeline model with an SRAM emulator.
module tb_sram_arbiter;

  localparam int NI = 3;
  localparam int WV [NI] = '{1, 2, 15};
  localparam int NA = 8;
  localparam logic [19:0] ATAB [NA] = '{20'h00012, 20'h00100, 20'h00013, 20'hFFFFF,
                                        20'h00000, 20'h00055, 20'h00099, 20'h80001};

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [19:0] cpu_addr, ldr_addr;
  logic [15:0] cpu_wdata, ldr_wdata;

  logic        cpu_rdy_w [NI];
  logic        ldr_rdy_w [NI];
  logic [15:0] cpu_rd_w  [NI];
  logic [15:0] ldr_rd_w  [NI];
  logic        ce_n [NI], oe_n [NI], we_n [NI], ub_n [NI], lb_n [NI], doe [NI];
  logic [19:0] addr_w [NI];
  logic [15:0] dto [NI];
  logic [15:0] dfs [NI];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_arbiter #(.WAIT_CYCLES(WV[g]), .ADDR_W(20)) u_dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdy        (cpu_rdy_w[g]),
      .cpu_rdata      (cpu_rd_w[g]),
      .ldr_req        (ldr_req),
      .ldr_we         (ldr_we),
      .ldr_addr       (ldr_addr),
      .ldr_wdata      (ldr_wdata),
      .ldr_rdy        (ldr_rdy_w[g]),
      .ldr_rdata      (ldr_rd_w[g]),
      .CE_N           (ce_n[g]),
      .OE_N           (oe_n[g]),
      .WE_N           (we_n[g]),
      .UB_N           (ub_n[g]),
      .LB_N           (lb_n[g]),
      .ADDR           (addr_w[g]),
      .Data_to_sram   (dto[g]),
      .Data_oe        (doe[g]),
      .Data_from_sram (dfs[g])
    );
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: a transfer is an interval; m_p counts edges since its grant edge.
  bit          m_busy [NI];
  int          m_p    [NI];
  bit          m_port [NI];
  bit          m_we   [NI];
  logic [19:0] m_addr [NI];
  logic [15:0] m_wd   [NI];
  bit          m_last [NI];
  logic [15:0] m_rd   [NI][2];
  bit   [15:0] mmem   [NI][NA+1];
  bit          mval   [NI][NA+1];
  bit   [15:0] smem   [NI][NA+1];
  bit          sval   [NI][NA+1];

  function automatic int slot(input logic [19:0] a);
    for (int j = 0; j < NA; j++) if (a === ATAB[j]) return j;
    return NA;
  endfunction

  function automatic logic [15:0] dflt(input logic [19:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic bit pick(input bit c, input bit l, input bit last);
    return (c && l) ? !last : l;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!Reset_n) begin
        m_busy[i]  <= 1'b0;
        m_p[i]     <= 0;
        m_last[i]  <= 1'b1;
        m_rd[i][0] <= '0;
        m_rd[i][1] <= '0;
      end else if (!m_busy[i]) begin
        if (cpu_req || ldr_req) begin
          automatic bit          g  = pick(cpu_req, ldr_req, m_last[i]);
          automatic bit          w  = g ? ldr_we : cpu_we;
          automatic logic [19:0] a  = g ? ldr_addr : cpu_addr;
          automatic logic [15:0] d  = g ? ldr_wdata : cpu_wdata;
          m_busy[i] <= 1'b1;
          m_p[i]    <= 0;
          m_port[i] <= g;
          m_last[i] <= g;
          m_we[i]   <= w;
          m_addr[i] <= a;
          m_wd[i]   <= d;
          if (w) begin
            mmem[i][slot(a)] <= d;
            mval[i][slot(a)] <= 1'b1;
          end
        end
      end else begin
        if (m_p[i] == WV[i] - 1 && !m_we[i])
          m_rd[i][m_port[i]] <= mval[i][slot(m_addr[i])] ? mmem[i][slot(m_addr[i])] : dflt(m_addr[i]);
        if (m_p[i] == WV[i]) m_busy[i] <= 1'b0;
        m_p[i] <= m_p[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d (W=%0d) cycle %0d: got %h expected %h", nm, i, WV[i], cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      automatic bit acc = m_busy[i] && (m_p[i] < WV[i]);
      automatic bit dn  = m_busy[i] && (m_p[i] == WV[i]);
      chk("CE_N", i, ce_n[i], !m_busy[i]);
      chk("UB_N", i, ub_n[i], !m_busy[i]);
      chk("LB_N", i, lb_n[i], !m_busy[i]);
      chk("OE_N", i, oe_n[i], !(acc && !m_we[i]));
      chk("WE_N", i, we_n[i], !(acc && m_we[i]));
      chk("Data_oe", i, doe[i], m_busy[i] && m_we[i]);
      chk("ADDR", i, addr_w[i], m_busy[i] ? m_addr[i] : 20'h0);
      chk("cpu_rdy", i, cpu_rdy_w[i], dn && !m_port[i]);
      chk("ldr_rdy", i, ldr_rdy_w[i], dn && m_port[i]);
      chk("cpu_rdata", i, cpu_rd_w[i], m_rd[i][0]);
      chk("ldr_rdata", i, ldr_rd_w[i], m_rd[i][1]);
      if (m_busy[i] && m_we[i]) chk("Data_to_sram", i, dto[i], m_wd[i]);
    end
  endtask

  // Asynchronous SRAM emulator driven purely by the DUT strobes.
  task automatic emulate();
    for (int i = 0; i < NI; i++) begin
      automatic int s = slot(addr_w[i]);
      if (ce_n[i] === 1'b0 && we_n[i] === 1'b0) begin
        smem[i][s] = dto[i];
        sval[i][s] = 1'b1;
      end
      dfs[i] = (ce_n[i] === 1'b0 && oe_n[i] === 1'b0) ? (sval[i][s] ? smem[i][s] : dflt(addr_w[i])) : 16'hDEAD;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    compare_all();
    emulate();
  endtask

  task automatic xfer(input bit port, input bit we, input logic [19:0] a, input logic [15:0] d);
    int lat [NI];
    int np  [NI];
    int wl  [NI];
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1; np[i] = 0; wl[i] = 0;
    end
    if (port) begin ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
    else      begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int t = 0; t <= 20; t++) begin
      tick();
      if (t == 0) begin
        cpu_req = 1'b0; ldr_req = 1'b0;
        if (port) begin ldr_addr = 20'h00099; ldr_wdata = ~d; end
        else      begin cpu_addr = 20'h00099; cpu_wdata = ~d; end
      end
      for (int i = 0; i < NI; i++) begin
        if ((port ? ldr_rdy_w[i] : cpu_rdy_w[i]) === 1'b1) begin
          np[i]++;
          if (lat[i] < 0) lat[i] = t;
        end
        if (we_n[i] === 1'b0) wl[i]++;
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk("rdy_latency_edges", i, lat[i], WV[i]);
      chk("rdy_pulse_count", i, np[i], 1);
      chk("we_low_cycles", i, wl[i], we ? WV[i] : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc [$];
    int pp [$];
    Reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    for (int i = 0; i < NI; i++) dfs[i] = 16'hDEAD;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_CE_N", i, ce_n[i], 1'b1);
      chk("reset_ADDR", i, addr_w[i], 20'h0);
      chk("reset_cpu_rdata", i, cpu_rd_w[i], 16'h0);
      chk("reset_Data_oe", i, doe[i], 1'b0);
    end

    // Tie from reset release: CPU first, then strict alternation.
    cpu_req = 1'b1; cpu_addr = 20'h00013;
    ldr_req = 1'b1; ldr_addr = 20'h00055;
    Reset_n = 1'b1;
    for (int t = 0; t < 40 && pc.size() < 4; t++) begin
      tick();
      if (cpu_rdy_w[1] === 1'b1) begin pc.push_back(cyc); pp.push_back(0); end
      if (ldr_rdy_w[1] === 1'b1) begin pc.push_back(cyc); pp.push_back(1); end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    chk("tie_pulses", 1, pc.size(), 4);
    for (int j = 0; j < pc.size(); j++) begin
      chk("tie_port_order", 1, pp[j], j % 2);
      if (j > 0) chk("tie_pulse_gap", 1, pc[j] - pc[j-1], 4);
    end
    repeat (20) tick();

    xfer(1'b0, 1'b1, 20'h00012, 16'hBEEF);
    xfer(1'b0, 1'b0, 20'h00012, 16'h0000);
    for (int i = 0; i < NI; i++) chk("cpu_read_back", i, cpu_rd_w[i], 16'hBEEF);

    xfer(1'b1, 1'b1, 20'h00100, 16'h1234);

    // Reset dropped during the second strobe cycle of a loader read.
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 20'h00100;
    tick();
    ldr_req = 1'b0;
    tick();
    #1 Reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("abort_CE_N", i, ce_n[i], 1'b1);
      chk("abort_OE_N", i, oe_n[i], 1'b1);
      chk("abort_WE_N", i, we_n[i], 1'b1);
      chk("abort_Data_oe", i, doe[i], 1'b0);
      chk("abort_ldr_rdy", i, ldr_rdy_w[i], 1'b0);
    end
    repeat (2) tick();
    Reset_n = 1'b1;
    for (int i = 0; i < NI; i++) chk("abort_ldr_rdata", i, ldr_rd_w[i], 16'h0);
    xfer(1'b1, 1'b0, 20'h00100, 16'h0000);
    for (int i = 0; i < NI; i++) chk("ldr_read_back", i, ldr_rd_w[i], 16'h1234);

    for (int it = 0; it < 2500; it++) begin
      tick();
      if (!Reset_n) Reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) Reset_n = 1'b0;
      if ($urandom_range(0, 3) == 0) cpu_req = !cpu_req;
      if ($urandom_range(0, 3) == 0) ldr_req = !ldr_req;
      if ($urandom_range(0, 1) == 0) begin
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ATAB[$urandom_range(0, NA-1)];
        cpu_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 1) == 0) begin
        ldr_we    = 1'($urandom_range(0, 1));
        ldr_addr  = ATAB[$urandom_range(0, NA-1)];
        ldr_wdata = 16'($urandom);
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0; Reset_n = 1'b1;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of SRAM access cycles per transfer (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 20, meaning the SRAM word-address width.
REQ-003 SHALL have port Clk, input, 1, the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have ports cpu_req / cpu_we, input, 1 each: CPU access request (level) and write-select.
REQ-006 SHALL have ports cpu_addr, input, ADDR_W and cpu_wdata, input, 16: CPU address (from MAR) and write data (from MDR).
REQ-007 SHALL have ports cpu_rdy, output, 1 and cpu_rdata, output, 16: one-cycle completion pulse and read data.
REQ-008 SHALL have ports ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdy and ldr_rdata, identical to the cpu_* ports, for the program-loader/debug port.
REQ-009 SHALL have ports CE_N, OE_N, WE_N, UB_N and LB_N, output, 1 each: active-low SRAM strobes.
REQ-010 SHALL have port ADDR, output, ADDR_W: the SRAM address.
REQ-011 SHALL have ports Data_to_sram, output, 16; Data_oe, output, 1; Data_from_sram, input, 16: the split tristate bus.

Function
REQ-012 SHALL implement the states IDLE, ACCESS and DONE.
REQ-013 In IDLE with at least one req high, SHALL grant one port, latch its addr/we/wdata and enter ACCESS at the next edge.
REQ-014 With both reqs high in IDLE, SHALL grant the port not granted last (round-robin); with a single req, SHALL grant that port.
REQ-015 SHALL stay in ACCESS exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then enter DONE.
REQ-016 In DONE, SHALL assert the granted port's rdy for exactly one cycle and then return to IDLE; the other port's rdy SHALL stay 0.
REQ-017 Latency: req sampled at edge k in IDLE -> rdy high during cycle k+WAIT_CYCLES+1; throughput one transfer per WAIT_CYCLES+2 cycles.
REQ-018 In ACCESS and DONE: CE_N=0, UB_N=0, LB_N=0, and ADDR SHALL equal the latched address, stable throughout.
REQ-019 Read: OE_N=0 in ACCESS; Data_from_sram SHALL be registered on the last ACCESS edge into the granted port's rdata, which holds until that port's next read completes.
REQ-020 Write: WE_N=0 and Data_oe=1 in ACCESS only; WE_N=1 in DONE (recovery cycle); Data_oe=1 in DONE as well (data hold), OE_N=1 throughout.
REQ-021 In IDLE, all strobes SHALL be 1, Data_oe=0 and ADDR=0.
REQ-022 req deasserted mid-transfer: the transfer SHALL complete and rdy SHALL still pulse; changes to addr/wdata after grant SHALL be ignored.
REQ-023 req held high after rdy: SHALL be treated as a new request in the following IDLE cycle; round-robin SHALL alternate when both stay high.
REQ-024 A new req arriving during ACCESS/DONE SHALL wait; no request SHALL be dropped while held.

Reset
REQ-025 Reset_n low SHALL immediately force IDLE; strobes=1; Data_oe=0; ADDR=0; rdy=0; rdata=0; counter=0; last-grant=LDR, so the CPU wins the first tie.
REQ-026 Reset mid-transfer SHALL abort it with no rdy pulse; operation SHALL resume from IDLE on the first edge after Reset_n goes high.

Structure
REQ-027 Package sram_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), the port enum (CPU, LDR) and the default WAIT_CYCLES/ADDR_W constants.
REQ-028 The block SHALL be flat with no sub-modules; the top level SHALL place the tristate driver from Data_to_sram/Data_oe.

Verification
REQ-029 Write then read: CPU write addr 0x00012 data 0xBEEF, then read 0x00012 -> cpu_rdy at cycle k+3 each (WAIT_CYCLES=2); cpu_rdata=0xBEEF; ldr_rdy stays 0.
REQ-030 Tie: both reqs high from reset release -> grants CPU, LDR, CPU, LDR; the rdy pulses are 4 cycles apart.
REQ-031 Write strobe: ldr write 0x00100 <- 0x1234 -> WE_N low exactly WAIT_CYCLES cycles; ADDR and Data_to_sram are stable from first ACCESS to DONE end.
REQ-032 Early drop: cpu_req high for 1 cycle only, cpu_addr changed after grant -> access uses the original address and cpu_rdy still pulses once.
REQ-033 Reset abort: Reset_n low in the 2nd ACCESS cycle -> strobes 1 asynchronously, no rdy; a subsequent read completes normally.
REQ-034 WAIT_CYCLES=1 and 15 -> rdy latency is 2 and 16 cycles respectively.
